// File: rtl/network_input_loader.sv
// Assembles 9 serial fixed-point samples into a registered frame for the Network, pulses start,
// then holds the frame until the Network signals end (or the wait times out).
module network_input_loader #(
  parameter int DATA_W     = 16,
  parameter int FRAC_SHIFT = 16,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     start,
  output logic signed [32:0]       input_0,
  output logic signed [32:0]       input_1,
  output logic signed [32:0]       input_2,
  output logic signed [32:0]       input_3,
  output logic signed [32:0]       input_4,
  output logic signed [32:0]       input_5,
  output logic signed [32:0]       input_6,
  output logic signed [32:0]       input_7,
  output logic signed [32:0]       input_8,
  input  logic                     net_end,
  output logic                     done,
  output logic                     frame_err,
  output logic                     timeout,
  output logic                     busy,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, FILL, SYNC, LAUNCH, WAIT} state_t;

  state_t                state, state_nx;
  logic [3:0]            idx, idx_nx;
  logic [TW-1:0]         timer, timer_nx;
  logic                  net_prev;
  logic                  beat, net_rise, expire;
  logic                  store, load, done_nx, err_nx, tmo_nx;
  logic signed [32:0]    conv;
  logic signed [32:0]    shadow [0:7];
  logic signed [32:0]    frame  [0:8];

  assign beat     = s_valid && s_ready;
  assign net_rise = net_end && !net_prev;
  assign expire   = (timer == TW'(TIMEOUT - 1));
  assign conv     = 33'(signed'(s_data)) <<< FRAC_SHIFT;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    timer_nx = timer;
    store    = 1'b0;
    load     = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    tmo_nx   = 1'b0;
    case (state)
      IDLE: begin
        state_nx = FILL;
        idx_nx   = 4'd0;
      end
      FILL: begin
        if (beat) begin
          if (idx != 4'd8) begin
            if (s_last) begin
              err_nx = 1'b1;
              idx_nx = 4'd0;
            end else begin
              store  = 1'b1;
              idx_nx = idx + 4'd1;
            end
          end else if (s_last) begin
            // The 9th sample bypasses the shadow so the frame appears one cycle after its beat.
            load     = 1'b1;
            state_nx = LAUNCH;
          end else begin
            err_nx   = 1'b1;
            state_nx = SYNC;
          end
        end
      end
      SYNC: begin
        if (beat && s_last) begin
          idx_nx   = 4'd0;
          state_nx = FILL;
        end
      end
      LAUNCH: begin
        timer_nx = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (net_rise) begin
          done_nx  = 1'b1;
          idx_nx   = 4'd0;
          state_nx = FILL;
        end else if (expire) begin
          tmo_nx   = 1'b1;
          idx_nx   = 4'd0;
          state_nx = FILL;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 4'd0;
      timer     <= '0;
      net_prev  <= 1'b0;
      s_ready   <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      frame_cnt <= '0;
      for (int k = 0; k < 8; k++) shadow[k] <= '0;
      for (int k = 0; k < 9; k++) frame[k] <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      timer     <= timer_nx;
      net_prev  <= net_end;
      s_ready   <= (state_nx == FILL) || (state_nx == SYNC);
      start     <= (state_nx == LAUNCH);
      busy      <= (state_nx == LAUNCH) || (state_nx == WAIT);
      done      <= done_nx;
      frame_err <= err_nx;
      timeout   <= tmo_nx;
      if (done_nx) frame_cnt <= frame_cnt + CNT_W'(1);
      if (store) shadow[idx[2:0]] <= conv;
      if (load) begin
        for (int k = 0; k < 8; k++) frame[k] <= shadow[k];
        frame[8] <= conv;
      end
    end
  end

  assign input_0 = frame[0];
  assign input_1 = frame[1];
  assign input_2 = frame[2];
  assign input_3 = frame[3];
  assign input_4 = frame[4];
  assign input_5 = frame[5];
  assign input_6 = frame[6];
  assign input_7 = frame[7];
  assign input_8 = frame[8];

endmodule
